bs_run_ctrl: RTL

Run sequencer for the Black-Scholes Monte-Carlo pipeline. It accepts RUN/ACK commands from the host, pulls exactly N Gaussian samples from the random-number source with a valid/ready handshake, and feeds them into the free-running float pipeline. It tracks in-flight samples with a latency-matched valid delay line, gates the output accumulators, and reports COMPLETE only after the last sample has been accumulated. This replaces the fixed clock-count termination.

---
 rtl/bs_pkg.sv | 16 +
 rtl/bs_valid_delay.sv | 30 +++
 rtl/bs_run_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/bs_pkg.sv
// Shared constants for the Black-Scholes Monte-Carlo run sequencer:
// state encodings, host command codes and the default pipeline latency.
package bs_pkg;

  localparam int PIPE_LAT_DEF = 50;

  localparam logic [3:0] CMD_RUN = 4'd1;
  localparam logic [3:0] CMD_ACK = 4'd2;

  // Encodings double as the externally visible status code.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ISSUE    = 4'd1;
  localparam logic [3:0] ST_COMPLETE = 4'd2;
  localparam logic [3:0] ST_DRAIN    = 4'd3;

endpackage

// File: rtl/bs_valid_delay.sv
// Single-bit DEPTH-stage shift register with asynchronous clear, used to
// carry latency-matched side-band flags alongside the float pipeline.
module bs_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) sr <= '0;
        else         sr <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) sr <= '0;
        else         sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/bs_run_ctrl.sv
// Run sequencer: pulls exactly nsample Gaussian samples into the float pipeline
// and reports COMPLETE only once the last one has reached the accumulators.
module bs_run_ctrl
  import bs_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [3:0]  cmd,
  input  logic [31:0] nsample,
  input  logic        grn_valid,
  input  logic [31:0] grn_data,
  output logic        grn_ready,
  output logic        issue_valid,
  output logic [31:0] issue_data,
  output logic        acc_clr,
  output logic        acc_en,
  output logic [31:0] issued_cnt,
  output logic [3:0]  status,
  output logic        done
);

  localparam int CNT_W = $clog2(PIPE_LAT + 2);

  logic [3:0]       state;
  logic [31:0]      nsample_q;
  logic [CNT_W-1:0] inflight;
  logic             xfer;
  logic             last_xfer;

  function automatic logic [CNT_W-1:0] next_inflight(input logic [CNT_W-1:0] cnt,
                                                     input logic            inc,
                                                     input logic            dec);
    case ({inc, dec})
      2'b10:   return cnt + CNT_W'(1);
      2'b01:   return cnt - CNT_W'(1);
      default: return cnt;
    endcase
  endfunction

  assign grn_ready = (state == ST_ISSUE) && (issued_cnt < nsample_q);
  assign xfer      = grn_valid && grn_ready;
  assign last_xfer = xfer && ((issued_cnt + 32'd1) == nsample_q);
  assign status    = state;
  assign done      = (state == ST_COMPLETE);

  // Control: run state, sample count and the one-shot accumulator clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      nsample_q  <= '0;
      issued_cnt <= '0;
      acc_clr    <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      case (state)
        ST_IDLE: begin
          nsample_q <= nsample;
          if (cmd == CMD_RUN) begin
            if (nsample == 32'd0) begin
              state <= ST_COMPLETE;
            end else begin
              state      <= ST_ISSUE;
              issued_cnt <= '0;
              acc_clr    <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (xfer)      issued_cnt <= issued_cnt + 32'd1;
          if (last_xfer) state      <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Last sample is out of the pipe once nothing is counted in flight
          // and nothing is being issued this cycle.
          if ((inflight == '0) && !issue_valid) state <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          if (cmd == CMD_ACK) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0 -> pipeline input: registered sample and its valid.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      issue_valid <= 1'b0;
      issue_data  <= '0;
    end else begin
      issue_valid <= xfer;
      if (xfer) issue_data <= grn_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) inflight <= '0;
    else         inflight <= next_inflight(inflight, issue_valid, acc_en);
  end

  // Pipeline input -> accumulator input: valid delayed by the datapath latency.
  bs_valid_delay #(
    .DEPTH (PIPE_LAT)
  ) u_valid_delay (
    .clk    (clk),
    .nreset (nreset),
    .din    (issue_valid),
    .dout   (acc_en)
  );

endmodule
